// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its operand sequencer.
//   - opcode constants (4-bit)
//   - flag bit positions within the 5-bit flag vector {err,neg,zero,carry,ovf}
//   - seq_state_t: sequencer phase encoding, also shown on the phase LEDs
package alu_pkg;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_MUL = 4'b0010;
   localparam logic [3:0] OP_DIV = 4'b0011;
   localparam logic [3:0] OP_MOD = 4'b0100;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_OR  = 4'b0110;
   localparam logic [3:0] OP_XOR = 4'b0111;
   localparam logic [3:0] OP_SHL = 4'b1000;
   localparam logic [3:0] OP_SHR = 4'b1001;

   localparam int unsigned F_ERR   = 4;
   localparam int unsigned F_NEG   = 3;
   localparam int unsigned F_ZERO  = 2;
   localparam int unsigned F_CARRY = 1;
   localparam int unsigned F_OVF   = 0;

   typedef enum logic [2:0] {
      SEQ_GET_A  = 3'd0,
      SEQ_GET_B  = 3'd1,
      SEQ_GET_OP = 3'd2,
      SEQ_EXEC   = 3'd3,
      SEQ_SHOW   = 3'd4
   } seq_state_t;

endpackage

// File: rtl/alu_operand_sequencer_btn_sync_edge.sv
// btn_sync_edge: synchronizes an asynchronous active-high button and emits a
// single-cycle pulse on its rising edge. A held button gives exactly one pulse.
// Ports:
//   clk    in   system clock
//   rst    in   synchronous active-high reset (clears all flops)
//   btn    in   asynchronous button level
//   pulse  out  one-cycle pulse on the synchronized rising edge
module btn_sync_edge #(
   parameter int unsigned SYNC_FF = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic pulse
);

   logic [SYNC_FF-1:0] sync;
   logic               prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync <= '0;
         prev <= 1'b0;
      end else begin
         sync <= {sync[SYNC_FF-2:0], btn};
         prev <= sync[SYNC_FF-1];
      end
   end

   assign pulse = sync[SYNC_FF-1] & ~prev;

endmodule

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: collects operand A, operand B and opcode from
// switches (each confirmed by Enter), drives an external combinational ALU,
// and captures its result/flags for display. In accumulate mode the captured
// result becomes the next operand A.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   sw, op_sw         operand / opcode switches
//   btn_enter         asynchronous Enter button
//   acc_mode          level: chain result into next A
//   alu_a/b/op        registered ALU inputs
//   alu_y, alu_f      ALU result and flags {err,neg,zero,carry,ovf}
//   result_q, flags_q captured result and flags
//   phase             current state code (0..4)
//   res_valid         captured result is fresh
module alu_operand_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned N       = 4,
   parameter int unsigned SYNC_FF = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] sw,
   input  logic [3:0]   op_sw,
   input  logic         btn_enter,
   input  logic         acc_mode,
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   output logic [3:0]   alu_op,
   input  logic [N-1:0] alu_y,
   input  logic [4:0]   alu_f,
   output logic [N-1:0] result_q,
   output logic [4:0]   flags_q,
   output logic [2:0]   phase,
   output logic         res_valid
);

   localparam logic [2:0] ST_GET_A  = SEQ_GET_A;
   localparam logic [2:0] ST_GET_B  = SEQ_GET_B;
   localparam logic [2:0] ST_GET_OP = SEQ_GET_OP;
   localparam logic [2:0] ST_EXEC   = SEQ_EXEC;
   localparam logic [2:0] ST_SHOW   = SEQ_SHOW;

   logic       enter_p;
   logic [2:0] state;
   logic [2:0] state_next;
   logic       chain;

   btn_sync_edge #(
      .SYNC_FF (SYNC_FF)
   ) u_enter (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_enter),
      .pulse (enter_p)
   );

   // Chaining is blocked when the captured result is marked invalid.
   assign chain = acc_mode & ~flags_q[F_ERR];

   always_comb begin
      state_next = state;
      case (state)
         ST_GET_A:  if (enter_p) state_next = ST_GET_B;
         ST_GET_B:  if (enter_p) state_next = ST_GET_OP;
         ST_GET_OP: if (enter_p) state_next = ST_EXEC;
         ST_EXEC:   state_next = ST_SHOW;   // enter_p here is dropped
         ST_SHOW:   if (enter_p) state_next = chain ? ST_GET_B : ST_GET_A;
         default:   state_next = ST_GET_A;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_GET_A;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= OP_ADD;
         result_q  <= '0;
         flags_q   <= '0;
         res_valid <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            ST_GET_A: begin
               if (enter_p) begin
                  alu_a     <= sw;
                  res_valid <= 1'b0;
               end
            end
            ST_GET_B: begin
               if (enter_p) alu_b <= sw;
            end
            ST_GET_OP: begin
               if (enter_p) alu_op <= op_sw;
            end
            ST_EXEC: begin
               // Operands were registered on an earlier edge, so alu_y/alu_f are settled.
               result_q  <= alu_y;
               flags_q   <= alu_f;
               res_valid <= 1'b1;
            end
            ST_SHOW: begin
               if (enter_p && chain) begin
                  alu_a     <= result_q;
                  res_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign phase = state;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a small behavioural ALU model.
module tb_alu_operand_sequencer;
   import alu_pkg::*;

   localparam int unsigned N = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] sw;
   logic [3:0]   op_sw;
   logic         btn_enter;
   logic         acc_mode;
   logic [N-1:0] alu_a, alu_b;
   logic [3:0]   alu_op;
   logic [N-1:0] alu_y;
   logic [4:0]   alu_f;
   logic [N-1:0] result_q;
   logic [4:0]   flags_q;
   logic [2:0]   phase;
   logic         res_valid;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_operand_sequencer #(
      .N       (N),
      .SYNC_FF (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sw        (sw),
      .op_sw     (op_sw),
      .btn_enter (btn_enter),
      .acc_mode  (acc_mode),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_op    (alu_op),
      .alu_y     (alu_y),
      .alu_f     (alu_f),
      .result_q  (result_q),
      .flags_q   (flags_q),
      .phase     (phase),
      .res_valid (res_valid)
   );

   // Behavioural ALU: y plus {err,neg,zero,carry,ovf}; divide/mod by zero gives y=0, err=1.
   always_comb begin
      logic [2*N-1:0] wide;
      logic           err;
      wide = '0;
      err  = 1'b0;
      case (alu_op)
         OP_ADD: wide = {{N{1'b0}}, alu_a} + {{N{1'b0}}, alu_b};
         OP_SUB: wide = {{N{1'b0}}, alu_a} - {{N{1'b0}}, alu_b};
         OP_MUL: wide = {{N{1'b0}}, alu_a} * {{N{1'b0}}, alu_b};
         OP_DIV: if (alu_b == '0) err = 1'b1; else wide = {{N{1'b0}}, alu_a / alu_b};
         OP_MOD: if (alu_b == '0) err = 1'b1; else wide = {{N{1'b0}}, alu_a % alu_b};
         OP_AND: wide = {{N{1'b0}}, alu_a & alu_b};
         OP_OR:  wide = {{N{1'b0}}, alu_a | alu_b};
         OP_XOR: wide = {{N{1'b0}}, alu_a ^ alu_b};
         OP_SHL: wide = {{N{1'b0}}, alu_a << 1};
         OP_SHR: wide = {{N{1'b0}}, alu_a >> 1};
         default: err = 1'b1;
      endcase
      alu_y = wide[N-1:0];
      alu_f = {err, wide[N-1], (wide[N-1:0] == '0), |wide[2*N-1:N], 1'b0};
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One Enter press: held 4 cycles, then 4 idle cycles so the edge detector re-arms.
   task automatic press();
      @(negedge clk) btn_enter = 1'b1;
      repeat (4) @(negedge clk);
      btn_enter = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; sw = '0; op_sw = '0; btn_enter = 1'b0; acc_mode = 1'b0;

      // 1. reset
      repeat (2) @(negedge clk);
      check_eq("rst_phase", phase, 0);
      check_eq("rst_a", alu_a, 0);
      check_eq("rst_b", alu_b, 0);
      check_eq("rst_op", alu_op, 0);
      check_eq("rst_res", result_q, 0);
      check_eq("rst_flags", flags_q, 0);
      check_eq("rst_valid", res_valid, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // 2. 3 + 1 via ADD, with capture latency checked
      sw = 4'b0011; press();
      check_eq("t2_a", alu_a, 4'b0011);
      check_eq("t2_phase_b", phase, 1);
      sw = 4'b0001; press();
      check_eq("t2_b", alu_b, 4'b0001);
      check_eq("t2_phase_op", phase, 2);
      @(negedge clk) begin op_sw = OP_ADD; btn_enter = 1'b1; end
      repeat (3) @(negedge clk);
      check_eq("t2_exec", phase, 3);
      check_eq("t2_exec_valid", res_valid, 0);
      @(negedge clk);
      check_eq("t2_show", phase, 4);
      check_eq("t2_res", result_q, 4'b0100);
      check_eq("t2_flags", flags_q, 5'b00000);
      check_eq("t2_valid", res_valid, 1);
      btn_enter = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("t2_hold", phase, 4);

      // 3. accumulate: 4 * 2
      acc_mode = 1'b1; press();
      check_eq("t3_a", alu_a, 4'b0100);
      check_eq("t3_phase_b", phase, 1);
      check_eq("t3_valid", res_valid, 0);
      sw = 4'b0010; press();
      check_eq("t3_phase_op", phase, 2);
      op_sw = OP_MUL; press();
      check_eq("t3_res", result_q, 4'b1000);
      check_eq("t3_phase", phase, 4);
      check_eq("t3_valid2", res_valid, 1);

      // 4. divide by zero blocks chaining
      acc_mode = 1'b0; press();
      check_eq("t4_to_a", phase, 0);
      sw = 4'b1000; press();
      sw = 4'b0000; press();
      op_sw = OP_DIV; press();
      check_eq("t4_flags", flags_q, 5'b10100);
      check_eq("t4_phase", phase, 4);
      acc_mode = 1'b1; press();
      check_eq("t4_blocked", phase, 0);
      check_eq("t4_a_held", alu_a, 4'b1000);
      check_eq("t4_valid_held", res_valid, 1);
      acc_mode = 1'b0;

      // 5. held button gives one advance; later sw changes ignored
      sw = 4'b0101;
      @(negedge clk) btn_enter = 1'b1;
      repeat (20) @(negedge clk);
      check_eq("t5_phase", phase, 1);
      check_eq("t5_a", alu_a, 4'b0101);
      sw = 4'b1111;
      repeat (3) @(negedge clk);
      check_eq("t5_a_stable", alu_a, 4'b0101);
      check_eq("t5_b_stable", alu_b, 4'b0000);
      btn_enter = 1'b0;
      repeat (4) @(negedge clk);

      // 6. reset coincident with the opcode-confirming pulse
      sw = 4'b0110; press();
      check_eq("t6_pre", phase, 2);
      @(negedge clk) begin op_sw = OP_XOR; btn_enter = 1'b1; end
      repeat (2) @(negedge clk);   // pulse is now high for the next edge
      rst = 1'b1; btn_enter = 1'b0;
      @(negedge clk);
      check_eq("t6_phase", phase, 0);
      check_eq("t6_op", alu_op, 0);
      check_eq("t6_valid", res_valid, 0);
      check_eq("t6_a", alu_a, 0);
      @(negedge clk) rst = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("t6_idle", phase, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
